// File: rtl/reg_read_stage.sv
// LC-3b decode/register-read stage: field extraction, per-register write scoreboard,
// RAW stall with same-cycle writeback bypass, and the AGEX pipeline latch.
module reg_read_stage #(
  parameter int SB_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_valid,
  input  logic [15:0] de_ir,
  output logic        de_ready,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  input  logic [15:0] rf_sr1_data,
  input  logic [15:0] rf_sr2_data,
  input  logic        wb_we,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        agex_valid,
  input  logic        agex_ready,
  output logic [15:0] agex_ir,
  output logic [15:0] agex_sr1_val,
  output logic [15:0] agex_sr2_val,
  output logic [2:0]  agex_dr,
  output logic        agex_dr_we
);

  localparam logic [1:0] LP_SB_MAX = 2'(SB_MAX);

  logic [1:0]  r_cnt [8];
  logic        r_agex_valid;
  logic [15:0] r_agex_ir;
  logic [15:0] r_agex_sr1_val;
  logic [15:0] r_agex_sr2_val;
  logic [2:0]  r_agex_dr;
  logic        r_agex_dr_we;

  logic [3:0]  w_op;
  logic [2:0]  w_sr1;
  logic [2:0]  w_sr2;
  logic        w_sr1_used;
  logic        w_sr2_used;
  logic [2:0]  w_dr;
  logic        w_dr_we;

  logic [1:0]  w_cnt_s1;
  logic [1:0]  w_cnt_s2;
  logic        w_byp1;
  logic        w_byp2;
  logic        w_haz1;
  logic        w_haz2;
  logic        w_haz_dst;
  logic        w_hazard;
  logic [15:0] w_val1;
  logic [15:0] w_val2;
  logic        w_issue;
  logic [7:0]  w_inc;
  logic [7:0]  w_dec;

  always_comb begin
    w_op       = de_ir[15:12];
    w_sr1      = de_ir[8:6];
    w_sr2      = de_ir[2:0];
    w_sr1_used = 1'b0;
    w_sr2_used = 1'b0;
    w_dr       = 3'd0;
    w_dr_we    = 1'b0;
    case (w_op)
      4'b0001, 4'b0101, 4'b1001: begin
        w_sr1_used = 1'b1;
        w_sr2_used = !de_ir[5];
        w_dr       = de_ir[11:9];
        w_dr_we    = 1'b1;
      end
      4'b1101, 4'b0010, 4'b0110: begin
        w_sr1_used = 1'b1;
        w_dr       = de_ir[11:9];
        w_dr_we    = 1'b1;
      end
      4'b0011, 4'b0111: begin
        w_sr1_used = 1'b1;
        w_sr2_used = 1'b1;
        w_sr2      = de_ir[11:9];
      end
      4'b1100: w_sr1_used = 1'b1;
      4'b0100: begin
        w_sr1_used = !de_ir[11];
        w_dr       = 3'd7;
        w_dr_we    = 1'b1;
      end
      4'b1110: begin
        w_dr    = de_ir[11:9];
        w_dr_we = 1'b1;
      end
      4'b1111: begin
        w_dr    = 3'd7;
        w_dr_we = 1'b1;
      end
      default: ;
    endcase
  end

  // A single outstanding write that retires this cycle can be forwarded; the
  // register file only sees the new value after the edge.
  always_comb begin
    w_cnt_s1  = r_cnt[w_sr1];
    w_cnt_s2  = r_cnt[w_sr2];
    w_byp1    = wb_we && (wb_dr == w_sr1) && (w_cnt_s1 == 2'd1);
    w_byp2    = wb_we && (wb_dr == w_sr2) && (w_cnt_s2 == 2'd1);
    w_haz1    = w_sr1_used && (w_cnt_s1 != 2'd0) && !w_byp1;
    w_haz2    = w_sr2_used && (w_cnt_s2 != 2'd0) && !w_byp2;
    w_haz_dst = w_dr_we && (r_cnt[w_dr] == LP_SB_MAX) && !(wb_we && (wb_dr == w_dr));
    w_hazard  = w_haz1 || w_haz2 || w_haz_dst;
    w_val1    = w_byp1 ? wb_data : rf_sr1_data;
    w_val2    = w_byp2 ? wb_data : rf_sr2_data;
    de_ready  = !w_hazard && (!r_agex_valid || agex_ready);
    w_issue   = de_valid && de_ready;
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < 8; i++) begin
      w_inc[i] = w_issue && w_dr_we && (w_dr == 3'(i));
      w_dec[i] = wb_we && (wb_dr == 3'(i)) && (r_cnt[i] != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 2'd1;
        else if (w_dec[i] && !w_inc[i])
          r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_agex_valid   <= 1'b0;
      r_agex_ir      <= 16'd0;
      r_agex_sr1_val <= 16'd0;
      r_agex_sr2_val <= 16'd0;
      r_agex_dr      <= 3'd0;
      r_agex_dr_we   <= 1'b0;
    end else if (w_issue) begin
      r_agex_valid   <= 1'b1;
      r_agex_ir      <= de_ir;
      r_agex_sr1_val <= w_val1;
      r_agex_sr2_val <= w_val2;
      r_agex_dr      <= w_dr;
      r_agex_dr_we   <= w_dr_we;
    end else if (agex_ready) begin
      r_agex_valid <= 1'b0;
    end
  end

  assign rf_sr1       = w_sr1;
  assign rf_sr2       = w_sr2;
  assign agex_valid   = r_agex_valid;
  assign agex_ir      = r_agex_ir;
  assign agex_sr1_val = r_agex_sr1_val;
  assign agex_sr2_val = r_agex_sr2_val;
  assign agex_dr      = r_agex_dr;
  assign agex_dr_we   = r_agex_dr_we;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios then random traffic, all checked
// against a table-driven reference model with a pending-write count per register.
module tb_reg_read_stage;

  localparam int SB_MAX = 3;
  // opcode membership masks, bit n set means opcode n belongs to the set
  localparam logic [15:0] M_SR1  = 16'h32EE;
  localparam logic [15:0] M_ALU  = 16'h0222;
  localparam logic [15:0] M_ST   = 16'h0088;
  localparam logic [15:0] M_DRIR = 16'h6266;
  localparam logic [15:0] M_DR7  = 16'h8010;

  typedef struct packed {
    logic       u1;
    logic       u2;
    logic       we;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] dr;
  } dec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, de_valid, de_ready, wb_we, agex_valid, agex_ready, agex_dr_we;
  logic [15:0] de_ir, rf_sr1_data, rf_sr2_data, wb_data, agex_ir, agex_sr1_val, agex_sr2_val;
  logic [2:0]  rf_sr1, rf_sr2, wb_dr, agex_dr;

  logic [15:0] rf [8];
  assign rf_sr1_data = rf[rf_sr1];
  assign rf_sr2_data = rf[rf_sr2];

  reg_read_stage #(.SB_MAX(SB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_ir(de_ir), .de_ready(de_ready),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_sr1_data(rf_sr1_data), .rf_sr2_data(rf_sr2_data),
    .wb_we(wb_we), .wb_dr(wb_dr), .wb_data(wb_data),
    .agex_valid(agex_valid), .agex_ready(agex_ready), .agex_ir(agex_ir),
    .agex_sr1_val(agex_sr1_val), .agex_sr2_val(agex_sr2_val),
    .agex_dr(agex_dr), .agex_dr_we(agex_dr_we)
  );

  int          pend [8] = '{default: 0};
  logic        m_av = 1'b0, m_we = 1'b0, m_u1 = 1'b0, m_u2 = 1'b0;
  logic [15:0] m_ir = '0, m_s1 = '0, m_s2 = '0;
  logic [2:0]  m_dr = '0;
  int          ncmp = 0;
  int          nerr = 0;
  logic        iss;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dec_t decode(input logic [15:0] ir);
    dec_t       d;
    logic [3:0] op;
    op   = ir[15:12];
    d.s1 = ir[8:6];
    d.u1 = M_SR1[op] || (op == 4'd4 && !ir[11]);
    d.s2 = M_ST[op] ? ir[11:9] : ir[2:0];
    d.u2 = M_ST[op] || (M_ALU[op] && !ir[5]);
    d.we = M_DRIR[op] || M_DR7[op];
    d.dr = M_DRIR[op] ? ir[11:9] : (M_DR7[op] ? 3'd7 : 3'd0);
    return d;
  endfunction

  task automatic resolve(input logic [2:0] s, input logic used, output logic haz, output logic [15:0] v);
    haz = 1'b0;
    v   = rf[s];
    if (pend[s] == 1 && wb_we && wb_dr == s) v = wb_data;
    else if (pend[s] != 0) haz = used;
  endtask

  // One clock: check combinational outputs, let the edge happen, advance the model,
  // then check the AGEX latch on the falling edge.
  task automatic cyc(output logic issued);
    dec_t        d;
    logic        h1, h2, hd, rdy;
    logic [15:0] v1, v2;
    #1;
    d = decode(de_ir);
    resolve(d.s1, d.u1, h1, v1);
    resolve(d.s2, d.u2, h2, v2);
    hd  = d.we && pend[d.dr] >= SB_MAX && !(wb_we && wb_dr == d.dr);
    rdy = !(h1 || h2 || hd) && (!m_av || agex_ready);
    if (rst_n) chk("de_ready", {15'd0, de_ready}, {15'd0, rdy});
    chk("rf_sr1", {13'd0, rf_sr1}, {13'd0, d.s1});
    chk("rf_sr2", {13'd0, rf_sr2}, {13'd0, d.s2});
    issued = rst_n && de_valid && rdy;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pend[i] = 0;
      m_av = 1'b0; m_ir = '0; m_s1 = '0; m_s2 = '0; m_dr = '0; m_we = 1'b0;
      m_u1 = 1'b1; m_u2 = 1'b1;
    end else begin
      if (wb_we && pend[wb_dr] > 0) pend[wb_dr]--;
      if (issued && d.we) pend[d.dr]++;
      if (issued) begin
        m_av = 1'b1; m_ir = de_ir; m_s1 = v1; m_s2 = v2; m_dr = d.dr; m_we = d.we;
        m_u1 = d.u1; m_u2 = d.u2;
      end else if (agex_ready) begin
        m_av = 1'b0;
      end
      if (wb_we) rf[wb_dr] = wb_data;
    end
    @(negedge clk);
    chk("agex_valid", {15'd0, agex_valid}, {15'd0, m_av});
    chk("agex_ir", agex_ir, m_ir);
    chk("agex_dr", {13'd0, agex_dr}, {13'd0, m_dr});
    chk("agex_dr_we", {15'd0, agex_dr_we}, {15'd0, m_we});
    if (m_u1) chk("agex_sr1_val", agex_sr1_val, m_s1);
    if (m_u2) chk("agex_sr2_val", agex_sr2_val, m_s2);
  endtask

  task automatic rf_init();
    for (int i = 0; i < 8; i++) rf[i] = 16'(i + 1);
  endtask

  initial begin
    rf_init();
    rst_n = 1'b0; de_valid = 1'b1; de_ir = 16'h1283; agex_ready = 1'b1;
    wb_we = 1'b1; wb_dr = 3'd1; wb_data = 16'hDEAD;
    cyc(iss);
    wb_we = 1'b0;
    cyc(iss);
    chk("rst_valid", {15'd0, agex_valid}, 16'd0);

    rst_n = 1'b1;
    cyc(iss);
    chk("add_sr1", agex_sr1_val, 16'd3);
    chk("add_sr2", agex_sr2_val, 16'd4);
    chk("add_dr", {13'd0, agex_dr}, 16'd1);

    de_ir = 16'h1841;
    cyc(iss);
    chk("raw_stall", {15'd0, iss}, 16'd0);
    cyc(iss);
    wb_we = 1'b1; wb_dr = 3'd1; wb_data = 16'h0007;
    cyc(iss);
    chk("bypass_issue", {15'd0, iss}, 16'd1);
    chk("bypass_sr1", agex_sr1_val, 16'd7);
    chk("bypass_sr2", agex_sr2_val, 16'd7);
    wb_we = 1'b0;

    de_ir = 16'h7B80;
    cyc(iss);
    chk("stw_sr1", agex_sr1_val, 16'd7);
    chk("stw_sr2", agex_sr2_val, 16'd6);
    chk("stw_we", {15'd0, agex_dr_we}, 16'd0);

    de_ir = 16'h1283;
    for (int k = 0; k < 3; k++) cyc(iss);
    cyc(iss);
    chk("sat_stall", {15'd0, iss}, 16'd0);
    wb_we = 1'b1; wb_dr = 3'd1; wb_data = 16'h0011;
    cyc(iss);
    chk("sat_issue", {15'd0, iss}, 16'd1);
    wb_we = 1'b0;

    agex_ready = 1'b0; de_ir = 16'h5000;
    for (int k = 0; k < 5; k++) begin
      cyc(iss);
      chk("bp_hold_ir", agex_ir, 16'h1283);
    end
    agex_ready = 1'b1;
    cyc(iss);
    chk("bp_release_ir", agex_ir, 16'h5000);

    rf_init();
    de_ir = 16'h1283; wb_we = 1'b1; wb_dr = 3'd1; wb_data = 16'h0002;
    cyc(iss);
    wb_we = 1'b0; de_valid = 1'b0; rst_n = 1'b0;
    cyc(iss);
    rst_n = 1'b1; de_valid = 1'b1; de_ir = 16'h1841;
    cyc(iss);
    chk("post_rst_issue", {15'd0, iss}, 16'd1);
    chk("post_rst_sr1", agex_sr1_val, 16'd2);

    for (int n = 0; n < 600; n++) begin
      if (!(de_valid && !iss)) begin
        de_valid = ($urandom % 4) != 0;
        de_ir    = 16'($urandom);
      end
      agex_ready = ($urandom % 4) != 0;
      wb_we      = ($urandom % 3) == 0;
      wb_dr      = 3'($urandom);
      wb_data    = 16'($urandom);
      rst_n      = ($urandom % 97) != 0;
      cyc(iss);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
